// File: rtl/mbe_pkg.sv
// Shared types and helpers for the pipelined modified-Booth multiplier.
package mbe_pkg;

  // Control FSM: INIT for one cycle after reset, then RUN until the next reset.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mbe_core.sv
// Combinational radix-4 modified-Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// is_signed selects two's-complement (1) or unsigned (0) operands.
// The multiplier is extended by at least one bit so that unsigned operands
// with the top bit set still recode correctly; all arithmetic is modulo
// 2^(2*WIDTH), which is exact because the true product always fits.
module mbe_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int NG = (WIDTH + 2) / 2;  // Booth groups covering WIDTH+1 bits

  logic          sa;
  logic          sb;
  logic [PW-1:0] a_ext;
  logic [2*NG:0] b_ext;                 // extended multiplier with implicit b[-1]=0
  logic [PW-1:0] acc;
  logic [PW-1:0] pp;
  logic [2:0]    sel;

  assign sa    = is_signed & a[WIDTH-1];
  assign sb    = is_signed & b[WIDTH-1];
  assign a_ext = {{(PW - WIDTH){sa}}, a};
  assign b_ext = {{(2 * NG - WIDTH){sb}}, b, 1'b0};

  // Recode each overlapping 3-bit group into a digit in {-2..2} and sum the
  // shifted partial products.
  always_comb begin
    acc = '0;
    pp  = '0;
    sel = '0;
    for (int i = 0; i < NG; i++) begin
      sel = b_ext[2*i +: 3];
      case (sel)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    p = acc;
  end

endmodule

// File: rtl/mbe_mult_pipe.sv
// Pipelined Booth multiplier with a credit-controlled output FIFO.
// Optional macro MBE_MULT_TRACE_EN carries the operands alongside each
// result and prints every output transfer; port timing is unchanged.
//
// Handshake: a beat moves on a rising edge where valid && ready. in_ready is
// a function of registers only (no path from in_valid or out_ready), and
// out_valid/out_data come straight from the FIFO head register state.
module mbe_mult_pipe
  import mbe_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PIPE_DEPTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data
);

  localparam int PW = 2 * WIDTH;
`ifdef MBE_MULT_TRACE_EN
  localparam int EW = PW + 2 * WIDTH + 1;  // {signed, a, b, product}
`else
  localparam int EW = PW;                  // product only
`endif
  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic [PW-1:0] prod;
  logic [EW-1:0] entry_in;

  logic [PIPE_DEPTH-1:0] pv_q, pv_d;
  logic [EW-1:0]         pd_q [PIPE_DEPTH];
  logic [EW-1:0]         pd_d [PIPE_DEPTH];

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] head;

  logic        accept;
  logic        push_w;
  logic        pop_w;
  logic [31:0] occ;

  mbe_core #(.WIDTH(WIDTH)) u_core (
    .a         (in_a),
    .b         (in_b),
    .is_signed (in_signed),
    .p         (prod)
  );

`ifdef MBE_MULT_TRACE_EN
  assign entry_in = {in_signed, in_a, in_b, prod};
`else
  assign entry_in = prod;
`endif

  // Next state: INIT always moves to RUN; RUN holds until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT) state_d = RUN;
  end

  // Credit: buffered plus in-flight results must leave room for one more.
  // A pop on this edge is deliberately not counted as free space.
  always_comb begin
    occ = 32'(cnt_q);
    for (int i = 0; i < PIPE_DEPTH; i++) occ = occ + 32'(pv_q[i]);
    in_ready = (state_q == RUN) && (occ < 32'(FIFO_DEPTH));
  end

  assign accept    = in_valid && in_ready;
  assign push_w    = pv_q[PIPE_DEPTH-1];
  assign out_valid = (cnt_q != '0);
  assign pop_w     = out_valid && out_ready;
  assign head      = mem_q[rptr_q];
  assign out_data  = head[PW-1:0];

  // Pipeline shifts every cycle; credit guarantees the FIFO can take the tail.
  always_comb begin
    pv_d    = '0;
    pv_d[0] = accept;
    pd_d[0] = entry_in;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  // FIFO write/read pointers wrap naturally; fullness comes from the count.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_w) begin
      mem_d[wptr_q] = pd_q[PIPE_DEPTH-1];
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop_w) rptr_d = rptr_q + AW'(1);
    case ({push_w, pop_w})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers: reset clears state, valid bits, count and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      pv_q    <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Data registers: contents are qualified by the valid bits and count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PIPE_DEPTH; i++) pd_q[i] <= pd_d[i];
    for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= mem_d[j];
  end

`ifdef MBE_MULT_TRACE_EN
  // Report each result as it leaves, with the operands that produced it.
  always_ff @(posedge clk) begin
    if (!rst && pop_w)
      $display("MBE: A=%d B=%d signed=%b OUT=%d",
               head[PW+WIDTH +: WIDTH], head[PW +: WIDTH], head[EW-1],
               head[PW-1:0]);
  end
`endif

endmodule

// File: doc/mbe_mult_pipe.md
MBE_MULT_PIPE -- requirements
Module: mbe_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, must be at least 2.
REQ-002 Parameter PIPE_DEPTH, default 2: register stages between operand accept and the output buffer, must be at least 1.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer entries, must be a power of two and at least 2.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  operand pair valid.
REQ-007 in_ready  out  1  block can accept an operand pair this cycle.
REQ-008 in_a, in_b  in  WIDTH each  multiplicand and multiplier.
REQ-009 in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-010 out_valid  out  1  out_data holds a result.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 out_data  out  2*WIDTH  product.

Function
REQ-013 An operand pair SHALL be accepted on an edge where in_valid && in_ready; out_valid/out_data SHALL transfer on an edge where out_valid && out_ready.
REQ-014 The product SHALL be exact over the full 2*WIDTH bits, sign-extended when in_signed=1, with no truncation or saturation.
REQ-015 Control FSM states: INIT, then RUN. rst forces INIT; INIT goes to RUN on the next edge; RUN holds until rst. in_ready SHALL be 0 in INIT.
REQ-016 In RUN, in_ready = (fifo_count + inflight < FIFO_DEPTH), where inflight is the number of valid pipeline stages. The value is combinational from registers only, with no path from in_valid or out_ready.
REQ-017 A pop on the same edge SHALL NOT free credit for an accept on that edge (conservative credit).
REQ-018 Latency: a pair accepted at edge t is written to the FIFO at edge t+PIPE_DEPTH. With the FIFO empty, out_valid SHALL first be high in the cycle after edge t+PIPE_DEPTH. There is no bypass path.
REQ-019 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-020 Simultaneous FIFO push and pop SHALL keep fifo_count unchanged. Pop on an empty FIFO and push on a full FIFO cannot occur by construction, and the assertions in REQ-033 check both.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH. Full/empty SHALL be decided from the count, not from pointer equality alone.
REQ-022 out_data SHALL be held stable while out_valid && !out_ready.
REQ-023 The pipeline SHALL advance every cycle whatever the state of out_ready; credit control guarantees buffer space.

Reset
REQ-024 On an edge with rst=1: state=INIT, in_ready=0, out_valid=0, all pipeline valid bits=0, fifo_count=0, pointers=0.
REQ-025 out_data and pipeline data registers are don't-care after reset.
REQ-026 Reset mid-operation SHALL discard all in-flight and buffered results. No result from before reset may ever appear on the output.

Configuration
REQ-027 Macro MBE_MULT_TRACE_EN.
- When defined: each output transfer SHALL $display "MBE: A=%d B=%d signed=%b OUT=%d", and operands travel with the result through the pipeline and FIFO.
- When undefined: no display, and no operand storage in the pipeline or FIFO.
- The cycle behaviour at the ports SHALL be identical in both cases.

Structure
REQ-028 Package mbe_pkg SHALL hold the FSM state typedef (INIT, RUN) and the function computing the count width clog2(FIFO_DEPTH+1).
REQ-029 Sub-module mbe_core SHALL be a combinational, WIDTH-parametrised modified-Booth multiplier with a signed/unsigned mode input. It is instantiated once at the input stage.
REQ-030 The pipeline stages and the FIFO SHALL be in mbe_mult_pipe itself.

Verification
WIDTH=8, PIPE_DEPTH=2, FIFO_DEPTH=4 for all scenarios.
REQ-031 Scenarios the bench SHALL cover:
- Reset: rst held 2 cycles then released -> in_ready=0 in the first cycle after release, 1 in the next; out_valid=0 throughout.
- Unsigned 255*255 -> out_data=0xFE01 (65025), out_valid high in the cycle after edge t+2.
- Signed: -128*-128 -> 0x4000; -1*127 -> 0xFF81; in_signed=0 with 0xFF*0x7F -> 0x7E81.
- Backpressure: out_ready=0, 6 back-to-back valid pairs (1*1 .. 6*6) -> exactly 4 accepted, then in_ready=0. Raise out_ready -> outputs 1, 4, 9, 16 in order, then in_ready returns and pairs 5 and 6 give 25, 36.
- Reset mid-operation: 3 pairs in flight, rst for 1 cycle -> out_valid=0 and no stale result afterwards. A new pair 3*5 -> 15.
- Full throughput: out_ready=1, continuous valid -> one accept and one output per cycle after the initial latency, fifo_count never above 3.
REQ-032 Each scenario SHALL be run with and without MBE_MULT_TRACE_EN, with identical port waveforms in both runs.
REQ-033 The bench SHALL assert that push-when-full and pop-when-empty never occur.
